l2_pri_bank_arbiter: RTL and testbench

//  Shares one private L2 SRAM bank between two TCDM-style masters (0: FC data port, 1: CFI monitor).

---
 rtl/l2_pri_bank_arbiter.sv | 144 ++++++++++++++
 tb/tb_l2_pri_bank_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_pri_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l2_pri_bank_arbiter: two-master round-robin arbiter for a private L2 bank,  |
// | with optional post-reset zero-fill and in-order response routing.           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module l2_pri_bank_arbiter #(
  parameter int unsigned           ADDR_WIDTH      = 32,
  parameter int unsigned           DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 32'h1C000000,
  parameter int unsigned           MEM_WORDS       = 8192,
  parameter int unsigned           MAX_OUTSTANDING = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      init_en_i,
  output logic                      init_done_o,
  output logic                      err_o,
  input  logic [1:0]                m_req_i,
  input  logic [2*ADDR_WIDTH-1:0]   m_add_i,
  input  logic [1:0]                m_wen_i,
  input  logic [2*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [2*DATA_WIDTH-1:0]   m_wdata_i,
  output logic [1:0]                m_gnt_o,
  output logic [1:0]                m_r_valid_o,
  output logic [2*DATA_WIDTH-1:0]   m_r_rdata_o,
  output logic                      mem_req_o,
  output logic [ADDR_WIDTH-1:0]     mem_add_o,
  output logic                      mem_wen_o,
  output logic [DATA_WIDTH/8-1:0]   mem_be_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_r_valid_i,
  input  logic [DATA_WIDTH-1:0]     mem_r_rdata_i
);

  localparam int unsigned c_be_width  = DATA_WIDTH / 8;
  localparam int unsigned c_cnt_width = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned c_ptr_width = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned c_occ_width = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [c_cnt_width-1:0] c_last_word = c_cnt_width'(MEM_WORDS - 1);
  localparam logic [c_ptr_width-1:0] c_last_ptr  = c_ptr_width'(MAX_OUTSTANDING - 1);
  localparam logic [c_occ_width-1:0] c_fifo_full = c_occ_width'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_INIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [c_cnt_width-1:0] r_cnt;
  logic                   r_last_winner;
  logic [c_occ_width-1:0] r_fifo_cnt;
  logic [c_ptr_width-1:0] r_wr_ptr;
  logic [c_ptr_width-1:0] r_rd_ptr;
  logic                   r_tag_init [MAX_OUTSTANDING];
  logic                   r_tag_id   [MAX_OUTSTANDING];
  logic                   r_err;

  logic w_winner;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_head_init;
  logic w_head_id;

  assign w_full  = (r_fifo_cnt == c_fifo_full);
  assign w_empty = (r_fifo_cnt == '0);
  // With both masters requesting, the one that did not win last time goes first.
  assign w_winner = (m_req_i == 2'b11) ? ~r_last_winner : m_req_i[1];
  assign w_push   = mem_req_o && mem_gnt_i;
  assign w_pop    = mem_r_valid_i && !w_empty;

  always_comb begin
    w_state_next = r_state;
    mem_req_o    = 1'b0;
    m_gnt_o      = 2'b00;
    mem_add_o    = w_winner ? m_add_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_add_i[ADDR_WIDTH-1:0];
    mem_wen_o    = w_winner ? m_wen_i[1] : m_wen_i[0];
    mem_be_o     = w_winner ? m_be_i[2*c_be_width-1:c_be_width] : m_be_i[c_be_width-1:0];
    mem_wdata_o  = w_winner ? m_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata_i[DATA_WIDTH-1:0];
    case (r_state)
      S_BOOT: w_state_next = init_en_i ? S_INIT : S_RUN;
      S_INIT: begin
        mem_req_o   = !w_full;
        mem_add_o   = BASE_ADDR + ADDR_WIDTH'({r_cnt, 2'b00});
        mem_wen_o   = 1'b0;
        mem_be_o    = '1;
        mem_wdata_o = '0;
        if (w_push && (r_cnt == c_last_word)) w_state_next = S_DRAIN;
      end
      S_DRAIN: if (w_empty) w_state_next = S_RUN;
      S_RUN: begin
        mem_req_o = (|m_req_i) && !w_full;
        m_gnt_o   = {w_winner, ~w_winner} & {2{w_push}};
      end
      default: w_state_next = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= S_BOOT;
      r_cnt         <= '0;
      r_last_winner <= 1'b1;
      r_fifo_cnt    <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_INIT && w_push) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_RUN && w_push) r_last_winner <= w_winner;
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop) r_fifo_cnt <= r_fifo_cnt + 1'b1;
      else if (!w_push && w_pop) r_fifo_cnt <= r_fifo_cnt - 1'b1;
      if (mem_r_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  // Tag storage needs no reset: entries are only read while the occupancy says valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_tag_init[r_wr_ptr] <= (r_state == S_INIT);
      r_tag_id[r_wr_ptr]   <= w_winner;
    end
  end

  assign w_head_init = r_tag_init[r_rd_ptr];
  assign w_head_id   = r_tag_id[r_rd_ptr];

  assign m_r_valid_o[0] = w_pop && !w_head_init && !w_head_id;
  assign m_r_valid_o[1] = w_pop && !w_head_init && w_head_id;
  assign m_r_rdata_o    = {2{mem_r_rdata_i}};
  assign init_done_o    = (r_state == S_RUN);
  assign err_o          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_l2_pri_bank_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_l2_pri_bank_arbiter: vector table, corner sequences and random traffic  |
// | checked against a queue-based reference model.                              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_l2_pri_bank_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MW = 8;
  localparam int MAXO = 2;
  localparam logic [31:0] BASE = 32'h1C000000;
  localparam int P_BOOT = 0, P_INIT = 1, P_DRAIN = 2, P_RUN = 3;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            init_en_i;
  logic            init_done_o;
  logic            err_o;
  logic [1:0]      m_req_i;
  logic [2*AW-1:0] m_add_i;
  logic [1:0]      m_wen_i;
  logic [2*BW-1:0] m_be_i;
  logic [2*DW-1:0] m_wdata_i;
  logic [1:0]      m_gnt_o;
  logic [1:0]      m_r_valid_o;
  logic [2*DW-1:0] m_r_rdata_o;
  logic            mem_req_o;
  logic [AW-1:0]   mem_add_o;
  logic            mem_wen_o;
  logic [BW-1:0]   mem_be_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_r_valid_i;
  logic [DW-1:0]   mem_r_rdata_i;

  always #5 clk_i = ~clk_i;

  l2_pri_bank_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(BASE), .MEM_WORDS(MW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .init_en_i(init_en_i), .init_done_o(init_done_o),
    .err_o(err_o), .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o),
    .m_r_rdata_o(m_r_rdata_o), .mem_req_o(mem_req_o), .mem_add_o(mem_add_o),
    .mem_wen_o(mem_wen_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_r_valid_i(mem_r_valid_i), .mem_r_rdata_i(mem_r_rdata_i)
  );

  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic [1:0] e_gnt;
    logic       e_mreq;
    logic [1:0] e_rv;
  } vec_t;
  vec_t vecs[11];

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase, walk counter, queue of outstanding owners (-1 = init write).
  int ph, cnt, last;
  bit merr;
  int q[$];

  bit          e_req, e_acc;
  int          e_win;
  logic [1:0]  e_gnt, e_rv;
  logic [31:0] e_add, e_wdata;
  logic        e_wen;
  logic [3:0]  e_be;

  logic [1:0]  o_gnt, o_rv;
  logic        o_mreq, o_wr;
  logic [31:0] o_add;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = P_BOOT; cnt = 0; last = 1; merr = 0;
    q.delete();
  endtask

  task automatic model_eval();
    e_req = 0; e_win = 0; e_add = '0; e_wen = 0; e_be = '0; e_wdata = '0;
    if (ph == P_INIT) begin
      e_req = (q.size() < MAXO);
      e_add = BASE + 32'(4 * cnt);
      e_be  = 4'hF;
    end else if (ph == P_RUN) begin
      e_req   = (m_req_i != 2'b00) && (q.size() < MAXO);
      e_win   = (m_req_i == 2'b11) ? 1 - last : (m_req_i[1] ? 1 : 0);
      e_add   = m_add_i[e_win*AW +: AW];
      e_wen   = m_wen_i[e_win];
      e_be    = m_be_i[e_win*BW +: BW];
      e_wdata = m_wdata_i[e_win*DW +: DW];
    end
    e_acc = e_req && mem_gnt_i;
    e_gnt = (ph == P_RUN && e_acc) ? 2'(1 << e_win) : 2'b00;
    e_rv  = 2'b00;
    if (mem_r_valid_i && q.size() > 0 && q[0] >= 0) e_rv = 2'(1 << q[0]);
  endtask

  task automatic model_update();
    bit was_empty;
    was_empty = (q.size() == 0);
    if (mem_r_valid_i) begin
      if (q.size() > 0) void'(q.pop_front());
      else merr = 1;
    end
    case (ph)
      P_BOOT:  ph = init_en_i ? P_INIT : P_RUN;
      P_INIT:  if (e_acc) begin
                 q.push_back(-1);
                 if (cnt == MW - 1) ph = P_DRAIN;
                 cnt = (cnt + 1) % MW;
               end
      P_DRAIN: if (was_empty) ph = P_RUN;
      default: if (e_acc) begin
                 q.push_back(e_win);
                 last = e_win;
               end
    endcase
  endtask

  task automatic check_outputs();
    chk("mem_req", mem_req_o, e_req);
    chk("m_gnt", m_gnt_o, e_gnt);
    chk("m_r_valid", m_r_valid_o, e_rv);
    chk("init_done", init_done_o, ph == P_RUN);
    chk("err", err_o, merr);
    chk("r_rdata", m_r_rdata_o, {2{mem_r_rdata_i}});
    if (e_req) begin
      chk("mem_add", mem_add_o, e_add);
      chk("mem_wen", mem_wen_o, e_wen);
      chk("mem_be", mem_be_o, e_be);
      chk("mem_wdata", mem_wdata_o, e_wdata);
    end
  endtask

  // Entered at posedge+1; inputs applied, outputs checked near negedge, model stepped at posedge.
  task automatic run_cycle(input logic [1:0] req, input logic g, input logic rv);
    m_req_i = req; mem_gnt_i = g; mem_r_valid_i = rv;
    mem_r_rdata_i = $urandom;
    m_add_i = {$urandom, $urandom};
    m_wen_i = 2'($urandom);
    m_be_i = 8'($urandom);
    m_wdata_i = {$urandom, $urandom};
    #4;
    model_eval();
    check_outputs();
    o_gnt = m_gnt_o; o_mreq = mem_req_o; o_rv = m_r_valid_o; o_add = mem_add_o;
    o_wr = mem_req_o && mem_gnt_i && !init_done_o && !mem_wen_o;
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic do_reset(input logic en);
    init_en_i = en; rst_ni = 1'b0;
    m_req_i = 2'b00; mem_gnt_i = 1'b0; mem_r_valid_i = 1'b0;
    #1;
    chk("rst_gnt", m_gnt_o, 2'b00);
    chk("rst_r_valid", m_r_valid_o, 2'b00);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_init_done", init_done_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Runs the zero-fill walk, checking each DUT write address; stops in RUN or at stop_cnt.
  task automatic init_walk(input int stop_cnt, output int writes);
    bit done;
    writes = 0;
    done = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      run_cycle(2'b11, 1'b1, q.size() > 0);
      if (o_wr) begin
        chk("init_addr", o_add, BASE + 32'(4 * writes));
        writes++;
      end
      if (ph == P_RUN) done = 1;
      if (stop_cnt >= 0 && ph == P_INIT && cnt == stop_cnt) done = 1;
    end
    chk("init_walk_bound", done, 1'b1);
  endtask

  initial begin
    int w;
    vecs[0]  = '{2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 2'b00};
    vecs[1]  = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 2'b01};
    vecs[2]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10};
    vecs[3]  = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 2'b00};
    vecs[4]  = '{2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
    vecs[5]  = '{2'b11, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01};
    vecs[6]  = '{2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00};
    vecs[7]  = '{2'b10, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10};
    vecs[8]  = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 2'b10};
    vecs[9]  = '{2'b00, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01};
    vecs[10] = '{2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};

    rst_ni = 1'b0; init_en_i = 1'b0; m_req_i = '0; m_add_i = '0; m_wen_i = '0;
    m_be_i = '0; m_wdata_i = '0; mem_gnt_i = 1'b0; mem_r_valid_i = 1'b0; mem_r_rdata_i = '0;
    model_reset();
    @(posedge clk_i);
    #1;

    // Full zero-fill walk.
    do_reset(1'b1);
    init_walk(-1, w);
    chk("init_writes", w, 8);
    chk("init_done_after_walk", init_done_o, 1'b1);

    // Reset in the middle of the walk, then a complete restart from word 0.
    do_reset(1'b1);
    init_walk(5, w);
    chk("partial_writes", w, 5);
    do_reset(1'b1);
    init_walk(-1, w);
    chk("restart_writes", w, 8);

    // No init: RUN after the boot cycle, then the directed vector table.
    do_reset(1'b0);
    run_cycle(2'b00, 1'b0, 1'b0);
    chk("no_init_done", init_done_o, 1'b1);
    for (int i = 0; i < 11; i++) begin
      run_cycle(vecs[i].req, vecs[i].gnt, vecs[i].rv);
      chk($sformatf("vec%0d_gnt", i), o_gnt, vecs[i].e_gnt);
      chk($sformatf("vec%0d_mem_req", i), o_mreq, vecs[i].e_mreq);
      chk($sformatf("vec%0d_r_valid", i), o_rv, vecs[i].e_rv);
    end

    // Random traffic; the bank only answers while something is outstanding.
    for (int i = 0; i < 400; i++)
      run_cycle(2'($urandom), ($urandom_range(3) != 0), (q.size() > 0) && ($urandom_range(2) != 0));
    for (int i = 0; i < 6; i++)
      run_cycle(2'b00, 1'b0, q.size() > 0);
    chk("queue_drained", q.size(), 0);

    // Response with nothing outstanding: dropped, error sticks until reset.
    run_cycle(2'b00, 1'b0, 1'b1);
    chk("orphan_r_valid", o_rv, 2'b00);
    for (int i = 0; i < 3; i++)
      run_cycle(2'b01, 1'b1, q.size() > 0);
    chk("err_sticky", err_o, 1'b1);
    do_reset(1'b0);
    run_cycle(2'b00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
